// File: rtl/lcd_console_writer_if.sv
// Character-input and screen-memory write handshakes for lcd_console_writer.
// master: the console writer; slave: the character producer plus memory responder.
interface lcd_console_writer_if;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        bus_select;
    logic [3:0]  bus_wstrb;
    logic [9:0]  bus_addr;
    logic [31:0] bus_data;
    logic        bus_ready;

    modport master (
        input  ch_valid, ch_data, bus_ready,
        output ch_ready, bus_select, bus_wstrb, bus_addr, bus_data
    );

    modport slave (
        output ch_valid, ch_data, bus_ready,
        input  ch_ready, bus_select, bus_wstrb, bus_addr, bus_data
    );
endinterface

// File: rtl/lcd_console_writer.sv
// Turns an ASCII stream into byte writes of font indices to an ASCII screen memory.
// Optional macro LCD_CONSOLE_AUTOCLEAR_EN: blank every newly entered row before accepting more input.
module lcd_console_writer #(
    parameter int COLUMNS = 60,
    parameter int ROWS    = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_console_writer_if.master io,
    output logic [5:0]           cursor_col,
    output logic [4:0]           cursor_row
);
    localparam logic [5:0] LAST_COL    = 6'(COLUMNS - 1);
    localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);
    localparam logic [7:0] SCREEN_LAST = 8'(COLUMNS * ROWS / 4 - 1);
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
    localparam logic [7:0] ROW_LAST    = 8'(COLUMNS / 4 - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_CLR_SCREEN = 2'd2
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
        , ST_CLR_ROW  = 2'd3
`endif
    } state_e;

    function automatic logic [9:0] cell_offset(input logic [4:0] row, input logic [5:0] col);
        return 10'(row) * 10'(COLUMNS) + 10'(col);
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [9:0] offset);
        return 4'b0001 << offset[1:0];
    endfunction

    function automatic logic [31:0] glyph_word(input logic [7:0] ch);
        logic [7:0] idx;
        idx = {1'b0, ch[6:0] - 7'h20};
        return {4{idx}};
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        sel_q, sel_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic [7:0]  word_q, word_d;
    logic        erase_q, erase_d;
    logic [4:0]  next_row_s;
    logic [9:0]  cur_off_s;
    logic [9:0]  bs_off_s;

    assign next_row_s = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    assign cur_off_s  = cell_offset(row_q, col_q);
    assign bs_off_s   = cell_offset(row_q, col_q - 6'd1);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= 6'd0;
            row_q   <= 5'd0;
            sel_q   <= 1'b0;
            wstrb_q <= 4'h0;
            addr_q  <= 10'd0;
            data_q  <= 32'h0;
            ready_q <= 1'b0;
            word_q  <= 8'd0;
            erase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            word_q  <= word_d;
            erase_q <= erase_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        sel_d   = sel_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        data_d  = data_q;
        word_d  = word_q;
        erase_d = erase_q;
        case (state_q)
            ST_IDLE: begin
                if (io.ch_valid && ready_q) begin
                    if (io.ch_data >= 8'h20 && io.ch_data <= 8'h7E) begin
                        state_d = ST_WRITE;
                        sel_d   = 1'b1;
                        addr_d  = cur_off_s;
                        wstrb_d = lane_strobe(cur_off_s);
                        data_d  = glyph_word(io.ch_data);
                        erase_d = 1'b0;
                    end else begin
                        case (io.ch_data)
                            8'h0A: begin
                                col_d = 6'd0;
                                row_d = next_row_s;
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
                                state_d = ST_CLR_ROW;
                                addr_d  = cell_offset(next_row_s, 6'd0);
                                wstrb_d = 4'hF;
                                data_d  = 32'h0;
                                word_d  = 8'd0;
`endif
                            end
                            8'h0D: col_d = 6'd0;
                            8'h08: begin
                                // Backspace moves first, then blanks the cell it lands on
                                if (col_q != 6'd0) begin
                                    col_d   = col_q - 6'd1;
                                    state_d = ST_WRITE;
                                    sel_d   = 1'b1;
                                    addr_d  = bs_off_s;
                                    wstrb_d = lane_strobe(bs_off_s);
                                    data_d  = 32'h0;
                                    erase_d = 1'b1;
                                end else begin
                                    col_d = col_q;
                                end
                            end
                            8'h0C: begin
                                state_d = ST_CLR_SCREEN;
                                sel_d   = 1'b1;
                                addr_d  = 10'd0;
                                wstrb_d = 4'hF;
                                data_d  = 32'h0;
                                word_d  = 8'd0;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (io.bus_ready) begin
                    sel_d = 1'b0;
                    if (erase_q) begin
                        state_d = ST_IDLE;
                    end else if (col_q == LAST_COL) begin
                        col_d = 6'd0;
                        row_d = next_row_s;
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
                        state_d = ST_CLR_ROW;
                        addr_d  = cell_offset(next_row_s, 6'd0);
                        wstrb_d = 4'hF;
                        data_d  = 32'h0;
                        word_d  = 8'd0;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        col_d   = col_q + 6'd1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    sel_d = 1'b1;
                end
            end
            // Select drops for one cycle after every word so each handshake is distinct
            ST_CLR_SCREEN: begin
                if (!sel_q) begin
                    sel_d = 1'b1;
                end else if (io.bus_ready) begin
                    sel_d = 1'b0;
                    if (word_q == SCREEN_LAST) begin
                        state_d = ST_IDLE;
                        col_d   = 6'd0;
                        row_d   = 5'd0;
                    end else begin
                        word_d = word_q + 8'd1;
                        addr_d = addr_q + 10'd4;
                    end
                end else begin
                    sel_d = 1'b1;
                end
            end
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
            ST_CLR_ROW: begin
                if (!sel_q) begin
                    sel_d = 1'b1;
                end else if (io.bus_ready) begin
                    sel_d = 1'b0;
                    if (word_q == ROW_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        word_d = word_q + 8'd1;
                        addr_d = addr_q + 10'd4;
                    end
                end else begin
                    sel_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                sel_d   = 1'b0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Outputs come straight from registers
    always_comb begin
        io.ch_ready   = ready_q;
        io.bus_select = sel_q;
        io.bus_wstrb  = wstrb_q;
        io.bus_addr   = addr_q;
        io.bus_data   = data_q;
        cursor_col    = col_q;
        cursor_row    = row_q;
    end
endmodule

// File: tb/tb_lcd_console_writer.sv
// Directed plus randomized bench for lcd_console_writer with a screen-level reference model.
module tb_lcd_console_writer;
    localparam int COLUMNS = 60;
    localparam int ROWS    = 17;
    localparam int CELLS   = COLUMNS * ROWS;
    localparam int LOGSZ   = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;

    lcd_console_writer_if io();

    lcd_console_writer #(.COLUMNS(COLUMNS), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .io(io),
        .cursor_col(cursor_col), .cursor_row(cursor_row)
    );

    always #5 clk = ~clk;

    // Memory responder state
    int          delay_mode = 0;
    int          rand_delay = 0;
    int          wait_cnt = 0;
    int          wr_count = 0;
    int          sel_cycles = 0;
    int          proto_err = 0;
    logic        prev_hs = 1'b0;
    logic [9:0]  held_addr = 10'd0;
    logic [3:0]  held_wstrb = 4'd0;
    logic [31:0] held_data = 32'd0;
    logic [9:0]  log_addr  [0:LOGSZ-1];
    logic [3:0]  log_wstrb [0:LOGSZ-1];
    logic [31:0] log_data  [0:LOGSZ-1];
    logic [7:0]  dut_mem   [0:1023];

    assign io.bus_ready = io.bus_select && (wait_cnt >= ((delay_mode < 0) ? rand_delay : delay_mode));

    always @(posedge clk) begin
        prev_hs <= io.bus_select && io.bus_ready;
        if (io.bus_select) begin
            sel_cycles <= sel_cycles + 1;
            if (prev_hs || io.bus_wstrb == 4'h0 || io.bus_data != {4{io.bus_data[7:0]}})
                proto_err <= proto_err + 1;
            else if (wait_cnt != 0 && {io.bus_addr, io.bus_wstrb, io.bus_data} != {held_addr, held_wstrb, held_data})
                proto_err <= proto_err + 1;
            held_addr  <= io.bus_addr;
            held_wstrb <= io.bus_wstrb;
            held_data  <= io.bus_data;
            if (io.bus_ready) begin
                if (wr_count < LOGSZ) begin
                    log_addr[wr_count]  <= io.bus_addr;
                    log_wstrb[wr_count] <= io.bus_wstrb;
                    log_data[wr_count]  <= io.bus_data;
                end
                for (int l = 0; l < 4; l++)
                    if (io.bus_wstrb[l]) dut_mem[{io.bus_addr[9:2], 2'(l)}] <= io.bus_data[8*l +: 8];
                wr_count   <= wr_count + 1;
                wait_cnt   <= 0;
                rand_delay <= int'($urandom_range(0, 3));
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // Checking and reference model
    int         n_pass = 0;
    int         n_checks = 0;
    int         mcol, mrow, exp_writes, base, snap, mism;
    logic [7:0] exp_mem [0:1023];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse(input logic [7:0] ch);
        io.ch_valid = 1'b1;
        io.ch_data  = ch;
        @(negedge clk);
        io.ch_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] ch);
        int n;
        pulse(ch);
        n = 0;
        while (io.ch_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_char", {31'd0, io.ch_ready}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        io.ch_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(cursor_col), 32'(col));
        check({tag, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    task automatic model_advance_row();
        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
        for (int c = 0; c < COLUMNS; c++) exp_mem[mrow * COLUMNS + c] = 8'h00;
        exp_writes += COLUMNS / 4;
`endif
    endtask

    task automatic model_char(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            exp_mem[mrow * COLUMNS + mcol] = ch - 8'h20;
            exp_writes++;
            if (mcol == COLUMNS - 1) begin
                mcol = 0;
                model_advance_row();
            end else begin
                mcol++;
            end
        end else if (ch == 8'h0A) begin
            mcol = 0;
            model_advance_row();
        end else if (ch == 8'h0D) begin
            mcol = 0;
        end else if (ch == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                exp_mem[mrow * COLUMNS + mcol] = 8'h00;
                exp_writes++;
            end
        end else if (ch == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'h00;
            exp_writes += CELLS / 4;
            mcol = 0;
            mrow = 0;
        end
    endtask

    function automatic logic [7:0] pick_char();
        logic [7:0] others [8];
        int r;
        others = '{8'h00, 8'h07, 8'h09, 8'h1B, 8'h7F, 8'h80, 8'hA1, 8'hFF};
        r = int'($urandom_range(0, 99));
        if (r < 70)      return 8'($urandom_range(32, 126));
        else if (r < 78) return 8'h0A;
        else if (r < 84) return 8'h0D;
        else if (r < 92) return 8'h08;
        else if (r < 93) return 8'h0C;
        else             return others[$urandom_range(0, 7)];
    endfunction

    initial begin
        logic [7:0] ch;
        int n;
        io.ch_valid = 1'b0;
        io.ch_data  = 8'h00;

        // Reset values, ready low in the reset cycle and high afterwards
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, io.ch_ready}, 32'd0);
        check("rst_select", {31'd0, io.bus_select}, 32'd0);
        check("rst_wstrb", 32'(io.bus_wstrb), 32'd0);
        check("rst_addr", 32'(io.bus_addr), 32'd0);
        check("rst_data", io.bus_data, 32'd0);
        check_cursor("rst", 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_next", {31'd0, io.ch_ready}, 32'd1);

        // 'A' with an immediate responder completes in the first select cycle
        delay_mode = 0;
        base = wr_count;
        snap = sel_cycles;
        push(8'h41);
        check("a_count", 32'(wr_count - base), 32'd1);
        check("a_addr", 32'(log_addr[base]), 32'd0);
        check("a_wstrb", 32'(log_wstrb[base]), 32'd1);
        check("a_data", log_data[base], 32'h21212121);
        check("a_sel_cycles", 32'(sel_cycles - snap), 32'd1);
        check_cursor("a", 1, 0);

        // 61 x 'B' from reset wraps onto row 1
        do_reset();
        delay_mode = -1;
        base = wr_count;
        for (int i = 0; i < 61; i++) push(8'h42);
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
        check("b_count", 32'(wr_count - base), 32'd76);
`else
        check("b_count", 32'(wr_count - base), 32'd61);
`endif
        check("b_addr", 32'(log_addr[wr_count - 1]), 32'd60);
        check("b_wstrb", 32'(log_wstrb[wr_count - 1]), 32'd1);
        check("b_data", log_data[wr_count - 1], 32'h22222222);
        check_cursor("b", 1, 1);

        // Line feed on the last row wraps to row 0
        do_reset();
        delay_mode = 1;
        for (int i = 0; i < 16; i++) push(8'h0A);
        for (int i = 0; i < 5; i++) push(8'h78);
        check_cursor("lf_pre", 5, 16);
        base = wr_count;
        push(8'h0A);
        check_cursor("lf", 0, 0);
`ifdef LCD_CONSOLE_AUTOCLEAR_EN
        check("lf_count", 32'(wr_count - base), 32'd15);
        check("lf_first_addr", 32'(log_addr[base]), 32'd0);
        check("lf_last_addr", 32'(log_addr[wr_count - 1]), 32'd56);
        check("lf_data", log_data[wr_count - 1], 32'h0);
`else
        check("lf_count", 32'(wr_count - base), 32'd0);
`endif
        base = wr_count;
        push(8'h0D);
        push(8'h1B);
        check("cr_esc_count", 32'(wr_count - base), 32'd0);

        // Backspace at column 0 is a no-op, otherwise it blanks the previous cell
        do_reset();
        base = wr_count;
        push(8'h08);
        check("bs0_count", 32'(wr_count - base), 32'd0);
        check_cursor("bs0", 0, 0);
        push(8'h43);
        push(8'h08);
        check("bs_count", 32'(wr_count - base), 32'd2);
        check("bs_addr", 32'(log_addr[wr_count - 1]), 32'd0);
        check("bs_data", log_data[wr_count - 1], 32'h0);
        check("bs_wstrb", 32'(log_wstrb[wr_count - 1]), 32'd1);
        check_cursor("bs", 0, 0);

        // Form feed with a 3-cycle responder
        delay_mode = 3;
        push(8'h51);
        push(8'h52);
        base = wr_count;
        snap = sel_cycles;
        push(8'h0C);
        check("ff_count", 32'(wr_count - base), 32'd255);
        check("ff_last_addr", 32'(log_addr[wr_count - 1]), 32'h3F8);
        check("ff_wstrb", 32'(log_wstrb[wr_count - 1]), 32'hF);
        check("ff_data", log_data[wr_count - 1], 32'h0);
        check("ff_sel_cycles", 32'(sel_cycles - snap), 32'd1020);
        check_cursor("ff", 0, 0);
        check("proto_directed", 32'(proto_err), 32'd0);

        // Reset in the middle of a screen clear
        push(8'h44);
        delay_mode = 0;
        base = wr_count;
        pulse(8'h0C);
        n = 0;
        while (wr_count - base < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", 32'(wr_count - base), 32'd100);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_select", {31'd0, io.bus_select}, 32'd0);
        check_cursor("abort", 0, 0);
        snap = wr_count;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_writes", 32'(wr_count - snap), 32'd0);
        check("abort_idle_ready", {31'd0, io.ch_ready}, 32'd1);

        // Randomized traffic against the screen model
        do_reset();
        delay_mode = -1;
        mcol = 0;
        mrow = 0;
        exp_writes = 0;
        base = wr_count;
        push(8'h0C);
        model_char(8'h0C);
        for (int i = 0; i < 400; i++) begin
            ch = pick_char();
            push(ch);
            model_char(ch);
            if (i % 40 == 39) check_cursor("rand", mcol, mrow);
        end
        check("rand_writes", 32'(wr_count - base), 32'(exp_writes));
        mism = 0;
        for (int i = 0; i < CELLS; i++)
            if (dut_mem[i] !== exp_mem[i]) mism++;
        check("rand_screen_mismatches", 32'(mism), 32'd0);
        check("proto_total", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
